// File: rtl/reg_cmd_sequencer.sv
// Purpose: expands host commands into single-cycle register/ALU control pulses and returns the final register value.
// Latency: NOP 2, CLEAR/LOAD 3, INC/DEC/SHR/SHL 3+cnt, ALU 4 cycles from the acceptance edge to rsp_valid.
// Backpressure: one command in flight; cmd_ready is low until the response handshakes, and rsp_data is held while rsp_ready=0.
module reg_cmd_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [2:0]       cmd_aluoc,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic             reg_cl,
  output logic             reg_ld,
  output logic             reg_inc,
  output logic             reg_dec,
  output logic             reg_sr,
  output logic             reg_ir,
  output logic             reg_sl,
  output logic             reg_il,
  output logic [WIDTH-1:0] reg_in,
  input  logic [WIDTH-1:0] reg_out,
  output logic [2:0]       alu_oc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_f,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data
);

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_ISSUE, S_SETTLE, S_RESP} state_t;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_CLEAR = 3'd1;
  localparam logic [2:0] OP_LOAD  = 3'd2;
  localparam logic [2:0] OP_INC   = 3'd3;
  localparam logic [2:0] OP_DEC   = 3'd4;
  localparam logic [2:0] OP_SHR   = 3'd5;
  localparam logic [2:0] OP_SHL   = 3'd6;
  localparam logic [2:0] OP_ALU   = 3'd7;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               cl_q, cl_d, ld_q, ld_d, inc_q, inc_d, dec_q, dec_d;
  logic               sr_q, sr_d, ir_q, ir_d, sl_q, sl_d, il_q, il_d;
  logic [WIDTH-1:0]   reg_in_q, reg_in_d;
  logic [2:0]         alu_oc_q, alu_oc_d;
  logic [WIDTH-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;

  // Next state plus next values of every registered output; controls are derived from the state being entered.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    reg_in_d    = reg_in_q;
    alu_oc_d    = alu_oc_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    rsp_data_d  = rsp_data_q;
    cl_d  = 1'b0; ld_d = 1'b0; inc_d = 1'b0; dec_d = 1'b0;
    sr_d  = 1'b0; ir_d = 1'b0; sl_d  = 1'b0; il_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          data_d = cmd_data;
          // Only the repeatable ops honour the count; everything else is a single pulse.
          cnt_d  = (cmd_op >= OP_INC && cmd_op <= OP_SHL) ? cmd_cnt : '0;
          if (cmd_op == OP_NOP) begin
            state_d = S_SETTLE;
          end else if (cmd_op == OP_ALU) begin
            state_d  = S_EXEC;
            alu_a_d  = reg_out;
            alu_b_d  = cmd_data;
            alu_oc_d = cmd_aluoc;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_EXEC: begin
        // reg_in doubles as the holding register for the ALU result.
        reg_in_d = alu_f;
        state_d  = S_ISSUE;
      end
      S_ISSUE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        rsp_data_d = reg_out;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_ISSUE) begin
      case (op_d)
        OP_CLEAR: cl_d = 1'b1;
        OP_LOAD: begin
          ld_d     = 1'b1;
          reg_in_d = data_d;
        end
        OP_ALU:   ld_d  = 1'b1;
        OP_INC:   inc_d = 1'b1;
        OP_DEC:   dec_d = 1'b1;
        OP_SHR: begin
          sr_d = 1'b1;
          ir_d = data_d[0];
        end
        OP_SHL: begin
          sl_d = 1'b1;
          il_d = data_d[0];
        end
        default: ;
      endcase
    end

    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  // State and output registers with synchronous reset; reset abandons any command in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      cl_q <= 1'b0; ld_q <= 1'b0; inc_q <= 1'b0; dec_q <= 1'b0;
      sr_q <= 1'b0; ir_q <= 1'b0; sl_q  <= 1'b0; il_q  <= 1'b0;
      reg_in_q    <= '0;
      alu_oc_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      cl_q <= cl_d; ld_q <= ld_d; inc_q <= inc_d; dec_q <= dec_d;
      sr_q <= sr_d; ir_q <= ir_d; sl_q  <= sl_d;  il_q  <= il_d;
      reg_in_q    <= reg_in_d;
      alu_oc_q    <= alu_oc_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign reg_cl    = cl_q;
  assign reg_ld    = ld_q;
  assign reg_inc   = inc_q;
  assign reg_dec   = dec_q;
  assign reg_sr    = sr_q;
  assign reg_ir    = ir_q;
  assign reg_sl    = sl_q;
  assign reg_il    = il_q;
  assign reg_in    = reg_in_q;
  assign alu_oc    = alu_oc_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_reg_cmd_sequencer.sv
// Purpose: scoreboard bench for reg_cmd_sequencer with a behavioural 4-bit register and ALU.
// Latency: measures acceptance-to-rsp_valid cycles per command.
// Backpressure: exercises rsp_ready=0 holding a response while a new command waits.
module tb_reg_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_aluoc;
  logic [3:0] cmd_data;
  logic [1:0] cmd_cnt;
  logic       reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il;
  logic [3:0] reg_in;
  logic [3:0] reg_m = 4'h0;
  logic [2:0] alu_oc;
  logic [3:0] alu_a, alu_b, alu_f;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;

  reg_cmd_sequencer #(.WIDTH(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_aluoc(cmd_aluoc), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt),
    .reg_cl(reg_cl), .reg_ld(reg_ld), .reg_inc(reg_inc), .reg_dec(reg_dec),
    .reg_sr(reg_sr), .reg_ir(reg_ir), .reg_sl(reg_sl), .reg_il(reg_il),
    .reg_in(reg_in), .reg_out(reg_m),
    .alu_oc(alu_oc), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register model driven by the sequencer's control pulses.
  always @(posedge clk) begin
    if (reg_cl)       reg_m <= 4'h0;
    else if (reg_ld)  reg_m <= reg_in;
    else if (reg_inc) reg_m <= reg_m + 4'h1;
    else if (reg_dec) reg_m <= reg_m - 4'h1;
    else if (reg_sr)  reg_m <= {reg_ir, reg_m[3:1]};
    else if (reg_sl)  reg_m <= {reg_m[2:0], reg_il};
  end

  function automatic logic [3:0] alu_fn(input logic [2:0] oc, input logic [3:0] a, input logic [3:0] b);
    case (oc)
      3'd0: alu_fn = a + b;
      3'd1: alu_fn = a - b;
      3'd2: alu_fn = a & b;
      3'd3: alu_fn = a | b;
      3'd4: alu_fn = a ^ b;
      3'd5: alu_fn = ~a;
      3'd6: alu_fn = b;
      default: alu_fn = a;
    endcase
  endfunction
  assign alu_f = alu_fn(alu_oc, alu_a, alu_b);

  localparam logic [5:0] C_CL = 6'b100000, C_LD = 6'b010000, C_INC = 6'b001000;
  localparam logic [5:0] C_DEC = 6'b000100, C_SR = 6'b000010, C_SL = 6'b000001, C_NONE = 6'b000000;

  typedef struct {
    logic [3:0] data;
    int         lat;
    int         npulse;
    logic [5:0] ctl;
    logic       ir;
    logic       il;
    logic [3:0] rin;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic push_exp(input logic [3:0] d, input int lat, input int np, input logic [5:0] ctl,
                          input logic ir, input logic il, input logic [3:0] rin);
    exp_t e;
    e.data = d; e.lat = lat; e.npulse = np; e.ctl = ctl; e.ir = ir; e.il = il; e.rin = rin;
    exp_q.push_back(e);
  endtask

  // Present a command and hold it until accepted; returns at the negedge of the first post-accept cycle.
  task automatic send(input logic [2:0] op, input logic [2:0] oc, input logic [3:0] d, input logic [1:0] cnt);
    int k;
    @(negedge clk);
    cmd_op = op; cmd_aluoc = oc; cmd_data = d; cmd_cnt = cnt; cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  // Monitor: tracks acceptance, pulse shape and latency; pops and compares on each response handshake.
  initial begin
    int   acc_cyc, npulse, lat_seen;
    logic ctl_bad, prev_vld;
    logic [5:0] mask;
    exp_t e;
    acc_cyc = 0; npulse = 0; lat_seen = -1; ctl_bad = 1'b0; prev_vld = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_vld = 1'b0;
        continue;
      end
      if (cmd_valid && cmd_ready) begin
        acc_cyc = cyc + 1; npulse = 0; ctl_bad = 1'b0; lat_seen = -1;
      end
      mask = {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl};
      if (mask != 6'b0 || reg_ir || reg_il) begin
        npulse++;
        if (exp_q.size() > 0) begin
          if (mask !== exp_q[0].ctl || reg_ir !== exp_q[0].ir || reg_il !== exp_q[0].il ||
              (reg_ld && reg_in !== exp_q[0].rin))
            ctl_bad = 1'b1;
        end
      end
      if (rsp_valid && !prev_vld) lat_seen = cyc - acc_cyc + 1;
      prev_vld = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_data", int'(rsp_data), int'(e.data));
          chk("latency", lat_seen, e.lat);
          chk("pulse_count", npulse, e.npulse);
          chk("pulse_shape", int'(ctl_bad), 0);
        end
      end
    end
  end

  initial begin
    int n_inc, k;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_aluoc = '0; cmd_data = '0; cmd_cnt = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_controls", int'({reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il}), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_data", int'(rsp_data), 0);
    chk("rst_alu", int'({alu_oc, alu_a, alu_b}), 0);
    chk("rst_reg_in", int'(reg_in), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", int'(cmd_ready), 1);

    // Reset in the middle of INC cnt=3, after the 2nd pulse.
    send(3'd3, 3'd0, 4'h0, 2'd3);
    n_inc = int'(reg_inc);
    @(negedge clk);
    n_inc += int'(reg_inc);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_controls", int'({reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il}), 0);
    chk("midrst_rsp_valid", int'(rsp_valid), 0);
    chk("midrst_cmd_ready", int'(cmd_ready), 1);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      n_inc += int'(reg_inc);
    end
    chk("midrst_inc_pulses", n_inc, 2);

    // LOAD A; LOAD E, INC x4 wraps to 2, DEC x3 gives F.
    push_exp(4'hA, 3, 1, C_LD, 1'b0, 1'b0, 4'hA);  send(3'd2, 3'd0, 4'hA, 2'd0);
    push_exp(4'hE, 3, 1, C_LD, 1'b0, 1'b0, 4'hE);  send(3'd2, 3'd0, 4'hE, 2'd0);
    push_exp(4'h2, 6, 4, C_INC, 1'b0, 1'b0, 4'h0); send(3'd3, 3'd0, 4'h0, 2'd3);
    push_exp(4'hF, 5, 3, C_DEC, 1'b0, 1'b0, 4'h0); send(3'd4, 3'd0, 4'h0, 2'd2);

    // LOAD 1001, SHR x2 shifting in 1 -> 1110, SHL x1 shifting in 0 -> 1100.
    push_exp(4'h9, 3, 1, C_LD, 1'b0, 1'b0, 4'h9);  send(3'd2, 3'd0, 4'h9, 2'd0);
    push_exp(4'hE, 4, 2, C_SR, 1'b1, 1'b0, 4'h0);  send(3'd5, 3'd0, 4'h1, 2'd1);
    push_exp(4'hC, 3, 1, C_SL, 1'b0, 1'b0, 4'h0);  send(3'd6, 3'd0, 4'h2, 2'd0);

    // LOAD 5, ALU OR with 9 -> D; check operands during EXEC.
    push_exp(4'h5, 3, 1, C_LD, 1'b0, 1'b0, 4'h5);  send(3'd2, 3'd0, 4'h5, 2'd0);
    push_exp(4'hD, 4, 1, C_LD, 1'b0, 1'b0, 4'hD);  send(3'd7, 3'd3, 4'h9, 2'd0);
    chk("exec_alu_a", int'(alu_a), 5);
    chk("exec_alu_b", int'(alu_b), 9);
    chk("exec_alu_oc", int'(alu_oc), 3);
    chk("exec_no_ctl", int'({reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl}), 0);
    wait_drain();

    // Backpressure: CLEAR (count ignored) held in RESP while a NOP waits.
    rsp_ready = 1'b0;
    push_exp(4'h0, 3, 1, C_CL, 1'b0, 1'b0, 4'h0);  send(3'd1, 3'd0, 4'h7, 2'd3);
    push_exp(4'h0, 2, 0, C_NONE, 1'b0, 1'b0, 4'h0);
    cmd_op = 3'd0; cmd_data = 4'h0; cmd_cnt = 2'd0; cmd_valid = 1'b1;
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("bp_rsp_seen", int'(rsp_valid), 1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_rsp_valid", int'(rsp_valid), 1);
      chk("bp_rsp_data", int'(rsp_data), 0);
      chk("bp_cmd_ready", int'(cmd_ready), 0);
    end
    rsp_ready = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!cmd_ready && k < 20);
    chk("bp_accept_wait", k, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;

    // NOP returns the current register value untouched.
    push_exp(4'h7, 3, 1, C_LD, 1'b0, 1'b0, 4'h7);  send(3'd2, 3'd0, 4'h7, 2'd0);
    push_exp(4'h7, 2, 0, C_NONE, 1'b0, 1'b0, 4'h0); send(3'd0, 3'd0, 4'h3, 2'd2);
    wait_drain();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
